// File: rtl/lcd_ctrl_pkg.sv
// Shared types, o_lcd field positions, init ROM and cycle helpers for lcd_ctrl.
// The init ROM is only present when LCD_CTRL_INIT_EN is defined.
package lcd_ctrl_pkg;

  typedef enum logic [2:0] {
    PWRUP,
    INIT_LOAD,
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    WAIT
  } state_e;

  localparam int unsigned LCD_ON = 31;
  localparam int unsigned LCD_EN = 10;
  localparam int unsigned LCD_RS = 9;
  localparam int unsigned LCD_RW = 8;

`ifdef LCD_CTRL_INIT_EN
  localparam int unsigned INIT_COUNT = 6;
  localparam int unsigned INIT_IDX_W = 3;

  // Function set 8-bit/2-line (x3), display on, clear, entry mode increment
  function automatic logic [7:0] init_rom(input logic [INIT_IDX_W-1:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = 8'h38;
      3'd1:    b = 8'h38;
      3'd2:    b = 8'h38;
      3'd3:    b = 8'h0C;
      3'd4:    b = 8'h01;
      3'd5:    b = 8'h06;
      default: b = 8'h00;
    endcase
    return b;
  endfunction
`endif

  // ceil(time_ns / clk_ns), never less than one cycle
  function automatic int unsigned cycles(input int unsigned time_ns,
                                         input int unsigned clk_ns);
    int unsigned c;
    c = (time_ns + clk_ns - 1) / clk_ns;
    return (c == 0) ? 1 : c;
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter that saturates at zero; done_c flags a zero count.
module lcd_timer #(
  parameter int unsigned    W       = 20,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done_c
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= RST_VAL;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign done_c = (cnt_q == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780-style 8-bit write-only LCD controller with timed EN strobes.
// Define LCD_CTRL_INIT_EN to include the power-up wait and built-in init sequence.
module lcd_ctrl
  import lcd_ctrl_pkg::*;
#(
  parameter int unsigned CLK_PERIOD_NS = 20,
  parameter int unsigned TSU_NS        = 60,
  parameter int unsigned TEN_NS        = 460,
  parameter int unsigned TH_NS         = 20,
  parameter int unsigned TEXEC_US      = 40,
  parameter int unsigned TLONG_US      = 1640,
  parameter int unsigned TPWR_US       = 20000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_rs,
  input  logic [7:0]  i_data,
  output logic [31:0] o_lcd,
  output logic        o_init_done
);

  localparam int unsigned SETUP_CYC = cycles(TSU_NS, CLK_PERIOD_NS);
  localparam int unsigned EN_CYC    = cycles(TEN_NS, CLK_PERIOD_NS);
  localparam int unsigned HOLD_CYC  = cycles(TH_NS, CLK_PERIOD_NS);
  localparam int unsigned EXEC_CYC  = cycles(TEXEC_US * 1000, CLK_PERIOD_NS);
  localparam int unsigned LONG_CYC  = cycles(TLONG_US * 1000, CLK_PERIOD_NS);
  localparam int unsigned PWR_CYC   = cycles(TPWR_US * 1000, CLK_PERIOD_NS);

  // Counter sized for the largest interval so a reload can never wrap
  localparam int unsigned CNT_MAX = max2(max2(PWR_CYC, LONG_CYC),
                                         max2(max2(EXEC_CYC, EN_CYC),
                                              max2(SETUP_CYC, HOLD_CYC)));
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_CYC - 1);

`ifdef LCD_CTRL_INIT_EN
  localparam state_e           RST_STATE = PWRUP;
  localparam logic [CNT_W-1:0] RST_CNT   = CNT_W'(PWR_CYC - 1);
  localparam logic [INIT_IDX_W-1:0] INIT_LAST = INIT_IDX_W'(INIT_COUNT - 1);
`else
  localparam state_e           RST_STATE = IDLE;
  localparam logic [CNT_W-1:0] RST_CNT   = '0;
`endif

  state_e           state_q, state_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic             ready_d;
  logic             init_done_d;
  logic [31:0]      lcd_d;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_done;
  logic             first_entry;
  logic             long_wait;
`ifdef LCD_CTRL_INIT_EN
  logic [INIT_IDX_W-1:0] idx_q, idx_d;
`endif

  lcd_timer #(
    .W       (CNT_W),
    .RST_VAL (RST_CNT)
  ) u_timer (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done_c   (tmr_done)
  );

  // State, captured byte and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= RST_STATE;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      o_ready     <= 1'b0;
      o_init_done <= 1'b0;
      o_lcd       <= '0;
`ifdef LCD_CTRL_INIT_EN
      idx_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      o_ready     <= ready_d;
      o_init_done <= init_done_d;
      o_lcd       <= lcd_d;
`ifdef LCD_CTRL_INIT_EN
      idx_q       <= idx_d;
`endif
    end
  end

`ifdef LCD_CTRL_INIT_EN
  // The first function-set after power-up needs the long settle time
  assign first_entry = !o_init_done && (idx_q == '0);
`else
  assign first_entry = 1'b0;
`endif

  assign long_wait = first_entry ||
                     (!rs_q && (data_q[7:2] == 6'd0) && (data_q != 8'h00));

  // Next state, timer reloads and next output values
  always_comb begin
    state_d     = state_q;
    rs_d        = rs_q;
    data_d      = data_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    init_done_d = o_init_done;
`ifdef LCD_CTRL_INIT_EN
    idx_d       = idx_q;
`endif

    case (state_q)
`ifdef LCD_CTRL_INIT_EN
      PWRUP: begin
        if (tmr_done) state_d = INIT_LOAD;
      end
      INIT_LOAD: begin
        rs_d     = 1'b0;
        data_d   = init_rom(idx_q);
        state_d  = SETUP;
        tmr_load = 1'b1;
        tmr_val  = SETUP_LD;
      end
`endif
      IDLE: begin
        if (i_valid && o_ready) begin
          rs_d     = i_rs;
          data_d   = i_data;
          state_d  = SETUP;
          tmr_load = 1'b1;
          tmr_val  = SETUP_LD;
        end
      end
      SETUP: begin
        if (tmr_done) begin
          state_d  = PULSE;
          tmr_load = 1'b1;
          tmr_val  = EN_LD;
        end
      end
      PULSE: begin
        if (tmr_done) begin
          state_d  = HOLD;
          tmr_load = 1'b1;
          tmr_val  = HOLD_LD;
        end
      end
      HOLD: begin
        if (tmr_done) begin
          state_d  = WAIT;
          tmr_load = 1'b1;
          tmr_val  = long_wait ? LONG_LD : EXEC_LD;
        end
      end
      WAIT: begin
        if (tmr_done) begin
`ifdef LCD_CTRL_INIT_EN
          if (!o_init_done) begin
            if (idx_q == INIT_LAST) begin
              state_d     = IDLE;
              init_done_d = 1'b1;
            end else begin
              idx_d   = idx_q + INIT_IDX_W'(1);
              state_d = INIT_LOAD;
            end
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
      end
      default: state_d = RST_STATE;
    endcase

`ifndef LCD_CTRL_INIT_EN
    init_done_d = 1'b1;
`endif

    ready_d         = (state_d == IDLE);
    lcd_d           = '0;
    lcd_d[LCD_ON]   = 1'b1;
    lcd_d[LCD_EN]   = (state_d == PULSE);
    lcd_d[LCD_RS]   = rs_d;
    lcd_d[LCD_RW]   = 1'b0;
    lcd_d[7:0]      = data_d;
  end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Randomized self-checking bench for lcd_ctrl against a cycle-timeline model.
// Handles both builds (LCD_CTRL_INIT_EN defined or not).
module tb_lcd_ctrl;

  localparam int SETUP_C = 3;
  localparam int EN_C    = 23;
  localparam int HOLD_C  = 1;
  localparam int EXEC_C  = 50;
  localparam int LONG_C  = 100;
  localparam int PWR_C   = 50;
  localparam int SLOT_C  = 1 + SETUP_C + EN_C + HOLD_C;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_rs = 1'b0;
  logic [7:0]  i_data = 8'h00;
  logic        o_ready;
  logic [31:0] o_lcd;
  logic        o_init_done;

  always #10 clk = ~clk;

  lcd_ctrl #(
    .CLK_PERIOD_NS (20),
    .TSU_NS        (60),
    .TEN_NS        (460),
    .TH_NS         (20),
    .TEXEC_US      (1),
    .TLONG_US      (2),
    .TPWR_US       (1)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_rs        (i_rs),
    .i_data      (i_data),
    .o_lcd       (o_lcd),
    .o_init_done (o_init_done)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  logic [7:0] rom [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

  // Timeline model: a transfer starting at cycle s shows RS/DATA from s+1,
  // EN high s+SETUP+1 .. s+SETUP+EN, and releases the bus at s+SLOT+wait.
  int         cyc, s, w, idle_from, init_idx;
  bit         in_init, have_slot, m_done;
  logic       m_rs;
  logic [7:0] m_data;
  int         en_rises, last_rise, prev_rise, en_len, first_ready;
  logic       prev_en;
  logic [7:0] rise_data;

  function automatic int wait_len(input logic rs, input logic [7:0] d, input bit first);
    if (first || (rs == 1'b0 && d[7:2] == 6'd0 && d != 8'h00)) return LONG_C;
    return EXEC_C;
  endfunction

  task automatic model_reset();
    cyc = 0; have_slot = 0; init_idx = 0;
    en_rises = 0; last_rise = 0; prev_rise = 0; en_len = 0; prev_en = 1'b0;
    first_ready = -1; rise_data = 8'h00;
`ifdef LCD_CTRL_INIT_EN
    in_init = 1; m_done = 0; idle_from = 0;
`else
    in_init = 0; m_done = 1; idle_from = 1;
`endif
  endtask

  task automatic start_slot(input int at, input logic rs, input logic [7:0] d, input bit first);
    s = at; m_rs = rs; m_data = d; w = wait_len(rs, d, first);
    have_slot = 1; idle_from = at + SLOT_C + w;
  endtask

  // Compare process: checks every post-reset cycle against the model
  always @(negedge clk) begin
    logic        exp_ready, exp_en, rsd;
    logic [31:0] mask, exp_lcd;
    if (!rst_n) begin
      model_reset();
    end else begin
      cyc++;
      if (in_init) begin
        if (!have_slot) begin
          if (cyc == PWR_C) start_slot(cyc, 1'b0, rom[0], 1'b1);
        end else if (cyc == s + SLOT_C + w) begin
          if (init_idx == 5) begin
            in_init = 0; m_done = 1; idle_from = cyc;
          end else begin
            init_idx++;
            start_slot(cyc, 1'b0, rom[init_idx], 1'b0);
          end
        end
      end
      exp_ready = !in_init && (cyc >= idle_from);
      exp_en    = have_slot && (cyc > s + SETUP_C) && (cyc <= s + SETUP_C + EN_C);
      rsd       = have_slot && (cyc > s) && (cyc < s + SLOT_C + w);
      mask      = rsd ? 32'hFFFF_FFFF : 32'hFFFF_FD00;
      exp_lcd   = 32'h8000_0000 | (exp_en ? 32'h400 : 32'h0) |
                  (m_rs ? 32'h200 : 32'h0) | {24'h0, m_data};
      check("lcd", o_lcd & mask, exp_lcd & mask);
      check("ready", 32'(o_ready), 32'(exp_ready));
      check("init_done", 32'(o_init_done), 32'(m_done));

      if (o_lcd[10] && !prev_en) begin
        en_rises++; prev_rise = last_rise; last_rise = cyc;
        rise_data = o_lcd[7:0]; en_len = 0;
      end
      if (o_lcd[10]) en_len++;
      if (!o_lcd[10] && prev_en) check("en_width", 32'(en_len), 32'd23);
      prev_en = o_lcd[10];
      if (o_ready && first_ready < 0) first_ready = cyc;

      if (exp_ready && i_valid) start_slot(cyc, i_rs, i_data, 1'b0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ready(input int bound);
    int n;
    n = 0;
    while (!o_ready && n < bound) begin tick(); n++; end
    if (!o_ready) check("ready_timeout", 32'(o_ready), 32'd1);
  endtask

  task automatic send(input logic rs, input logic [7:0] d, output int lat);
    wait_ready(5000);
    i_valid = 1'b1; i_rs = rs; i_data = d;
    tick();
    i_valid = 1'b0;
    check("ready_drop", 32'(o_ready), 32'd0);
    lat = 1;
    while (!o_ready && lat < 1000) begin tick(); lat++; end
  endtask

  task automatic release_and_init();
    @(negedge clk); #5 rst_n = 1'b1;
    tick();
    check("on_after_1clk", 32'(o_lcd[31]), 32'd1);
`ifndef LCD_CTRL_INIT_EN
    check("ready_after_1clk", 32'(o_ready), 32'd1);
    check("done_after_1clk", 32'(o_init_done), 32'd1);
`endif
    wait_ready(2000);
    tick();
`ifdef LCD_CTRL_INIT_EN
    check("init_end_cycle", 32'(first_ready), 32'd618);
    check("init_en_count", 32'(en_rises), 32'd6);
    check("init_last_data", 32'(rise_data), 32'h06);
`else
    check("first_ready_cycle", 32'(first_ready), 32'd1);
    repeat (20) tick();
    check("no_en_before_req", 32'(en_rises), 32'd0);
`endif
  endtask

  initial begin
    int lat, r0, k;
    repeat (3) @(posedge clk);
    release_and_init();

    send(1'b1, 8'h41, lat);
    check("lat_data_41", 32'(lat), 32'd78);
    check("data_41", 32'(rise_data), 32'h41);
    send(1'b0, 8'h01, lat);
    check("lat_clear", 32'(lat), 32'd128);
    send(1'b0, 8'h80, lat);
    check("lat_ddram", 32'(lat), 32'd78);

    // valid held across two requests
    wait_ready(5000);
    i_valid = 1'b1; i_rs = 1'b1; i_data = 8'h55;
    tick();
    r0 = en_rises;
    i_data = 8'h66;
    k = 0;
    while (!o_ready && k < 1000) begin tick(); k++; end
    tick();
    i_valid = 1'b0;
    wait_ready(1000);
    tick();
    check("b2b_count", 32'(en_rises - r0), 32'd2);
    check("b2b_spacing", 32'(last_rise - prev_rise), 32'd78);
    check("b2b_data", 32'(rise_data), 32'h66);

    // valid while busy must be dropped
    i_valid = 1'b1; i_data = 8'h30;
    tick();
    i_valid = 1'b0;
    r0 = en_rises;
    repeat (5) tick();
    i_valid = 1'b1; i_data = 8'h99;
    tick();
    i_valid = 1'b0;
    repeat (40) tick();
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    wait_ready(1000);
    tick();
    check("busy_ignored", 32'(en_rises - r0), 32'd1);

    // random traffic
    repeat (1500) begin
      i_valid = ($urandom_range(0, 3) == 0);
      i_rs    = 1'($urandom_range(0, 1));
      k       = $urandom_range(0, 3);
      if (k == 0)      i_data = 8'h01;
      else if (k == 1) i_data = 8'h02;
      else if (k == 2) i_data = 8'($urandom_range(0, 3));
      else             i_data = 8'($urandom);
      tick();
    end
    i_valid = 1'b0;

    // reset in the middle of an EN pulse
    wait_ready(5000);
    i_valid = 1'b1; i_rs = 1'b1; i_data = 8'h5A;
    tick();
    i_valid = 1'b0;
    k = 0;
    while (!o_lcd[10] && k < 100) begin tick(); k++; end
    check("en_seen", 32'(o_lcd[10]), 32'd1);
    repeat (5) tick();
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check("rst_lcd", o_lcd, 32'h0);
    check("rst_ready", 32'(o_ready), 32'd0);
    check("rst_done", 32'(o_init_done), 32'd0);
    repeat (2) @(negedge clk);
    release_and_init();
    send(1'b1, 8'h7E, lat);
    check("post_rst_lat", 32'(lat), 32'd78);
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #(20 * 60000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/lcd_ctrl.md
LCD_CTRL -- requirements
Module: lcd_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning): CLK_PERIOD_NS, 20, clock period; TSU_NS, 60, RS/DATA setup before EN rise; TEN_NS, 460, EN high width; TH_NS, 20, RS/DATA hold after EN fall; TEXEC_US, 40, normal command/data execution wait; TLONG_US, 1640, clear/home execution wait; TPWR_US, 20000, power-up wait.
REQ-002 Cycle counts SHALL be ceil(time/CLK_PERIOD_NS), minimum 1; defaults give setup 3, EN 23, hold 1, exec 2000, long 82000, power-up 1000000.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- i_clk, in, 1, single clock.
- i_rst_n, in, 1, asynchronous active-low reset.
- i_valid, in, 1, request valid.
- o_ready, out, 1, controller idle, accepts request.
- i_rs, in, 1, 0 = instruction, 1 = data.
- i_data, in, 8, byte to write.
- o_lcd, out, 32, LCD word: [31] ON, [10] EN, [9] RS, [8] RW, [7:0] DATA, other bits 0.
- o_init_done, out, 1, init sequence complete.

Function
REQ-004 All outputs SHALL be registered.
REQ-005 States SHALL be PWRUP, INIT_LOAD, IDLE, SETUP, PULSE, HOLD, WAIT.
REQ-006 PWRUP SHALL count the power-up cycles, then go to INIT_LOAD.
REQ-007 INIT_LOAD SHALL issue init ROM entries 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 (RS=0), each via SETUP->PULSE->HOLD->WAIT, in order.
REQ-008 After the last entry's WAIT, the controller SHALL go to IDLE and set o_init_done=1; o_init_done stays 1 until reset.
REQ-009 o_ready SHALL be 1 only in IDLE.
REQ-010 A transfer SHALL occur on a cycle with i_valid&&o_ready; i_rs/i_data are captured, o_ready=0 the next cycle, state goes to SETUP.
REQ-011 The SETUP, PULSE and HOLD states SHALL last exactly setup, EN and hold cycles.
REQ-012 The EN bit (o_lcd[10]) SHALL be 1 only in PULSE.
REQ-013 RS and DATA SHALL be stable from the first SETUP cycle through the last HOLD cycle.
REQ-014 In WAIT, RS and DATA SHALL keep their last value.
REQ-015 WAIT SHALL last the long count when RS=0 and DATA[7:2]==0 and DATA!=0 (clear/home); otherwise it SHALL last the exec count.
REQ-016 The first init entry SHALL also use the long count.
REQ-017 After WAIT, the controller SHALL go to IDLE, or to the next init entry during init.
REQ-018 The controller SHALL accept no request while o_ready=0; i_valid without o_ready SHALL be ignored and not queued.
REQ-019 Back-to-back requests SHALL be accepted; i_valid held high is accepted on the first IDLE cycle after WAIT.
REQ-020 RW (o_lcd[8]) SHALL always be 0; the controller never reads.
REQ-021 ON (o_lcd[31]) SHALL be 1 from the first clock edge after reset release.
REQ-022 The timing counter SHALL be a single down-counter wide enough for the power-up count; it SHALL never wrap, and each state reloads it on entry.

Reset
REQ-023 Asserting i_rst_n=0 SHALL immediately force: state PWRUP, o_lcd=0, o_ready=0, o_init_done=0, ROM index 0.
REQ-024 Reset mid-transfer SHALL abort the transfer with EN dropping asynchronously; after release, the full power-up sequence restarts.

Configuration
REQ-025 Macro LCD_CTRL_INIT_EN SHALL select the init behaviour.
REQ-026 With LCD_CTRL_INIT_EN defined, PWRUP and the init ROM sequence SHALL be compiled in, per REQ-006 to REQ-008.
REQ-027 Without LCD_CTRL_INIT_EN, PWRUP, INIT_LOAD and the ROM SHALL be absent; reset exit goes to IDLE with o_init_done=1 and o_ready=1 on the first clock, and software performs the init.

Structure
REQ-028 Package lcd_ctrl_pkg SHALL hold the state enum, the bit positions of o_lcd fields (ON=31, EN=10, RS=9, RW=8), the init ROM contents and count, and a ceil-divide cycle function.
REQ-029 Sub-module lcd_timer SHALL be used: loadable down-counter with a done flag, instantiated once.

Verification (CLK_PERIOD_NS=20, TPWR_US=1, TEXEC_US=1, TLONG_US=2, macro defined unless noted)
REQ-030 Reset release -> o_lcd[31]=1 after 1 clock; 50 PWRUP cycles; six EN pulses with DATA 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06, each 23 cycles high; then o_init_done=1 and o_ready=1.
REQ-031 In IDLE, i_valid=1, i_rs=1, i_data=0x41 -> o_ready=0 the next cycle; RS=1, DATA=0x41 for 3 cycles before EN; EN high 23 cycles; hold 1 cycle; 50 wait cycles; then o_ready=1.
REQ-032 Request i_rs=0, i_data=0x01 -> wait of 100 cycles; i_data=0x80 -> wait of 50 cycles.
REQ-033 i_valid held high with two data bytes -> both accepted; the EN rising edges are exactly 3+23+1+50+1 cycles apart; i_valid pulsed while busy -> no extra EN pulse.
REQ-034 i_rst_n dropped during PULSE -> EN=0 and o_lcd=0 in the same cycle; after release, the init sequence repeats from 0x38.
REQ-035 Macro undefined, reset release -> o_ready=1 and o_init_done=1 after 1 clock; no EN pulse until the first request.
